// File: rtl/soc_data_interconnect.sv
// soc_data_interconnect: routes the core's load/store port to NUM_TARGETS
// address-decoded targets. One request in flight, registered response,
// decode-error reporting. Optional feature macro: SOC_IC_TIMEOUT_EN adds an
// ACCESS-state timeout counter that ends a stalled access with an error.
module soc_data_interconnect #(
  parameter int NUM_TARGETS    = 4,
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int REGION_SHIFT   = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          Clk_Core,
  input  logic                          Rst_Core,
  input  logic                          Req_Valid,
  output logic                          Req_Ready,
  input  logic [ADDR_W-1:0]             Mem_Data_Addr,
  input  logic [DATA_W-1:0]             Mem_Data_Write,
  input  logic [DATA_W/8-1:0]           Mem_Write_Ctrl,
  input  logic                          Mem_Read_Ctrl,
  output logic                          Rsp_Valid,
  output logic [DATA_W-1:0]             Mem_Data_Read,
  output logic                          Rsp_Error,
  output logic [NUM_TARGETS-1:0]        Tgt_Sel,
  output logic [REGION_SHIFT-1:0]       Tgt_Addr,
  output logic [DATA_W-1:0]             Tgt_Wdata,
  output logic [DATA_W/8-1:0]           Tgt_Wstrb,
  output logic                          Tgt_Read,
  input  logic [NUM_TARGETS-1:0]        Tgt_Ack,
  input  logic [NUM_TARGETS*DATA_W-1:0] Tgt_Rdata
);

  // IDX_EFF is the true index width (0 for a single target); IDX_W keeps
  // the index register at least one bit wide.
  localparam int IDX_EFF = $clog2(NUM_TARGETS);
  localparam int IDX_W   = (IDX_EFF > 0) ? IDX_EFF : 1;
  localparam int STRB_W  = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [REGION_SHIFT-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]        wdata_q, wdata_d;
  logic [STRB_W-1:0]        wstrb_q, wstrb_d;
  logic                     read_q, read_d;
  logic [NUM_TARGETS-1:0]   sel_q, sel_d;
  logic                     ready_q, ready_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic                     rsp_error_q, rsp_error_d;
  logic [DATA_W-1:0]        rdata_q, rdata_d;

  logic [ADDR_W-1:0]        region_bits;
  logic [IDX_W-1:0]         req_idx;
  logic                     decode_err;
  logic                     null_req;
  logic                     accept;
  logic                     ack_hit;
  logic                     timeout_hit;

`ifdef SOC_IC_TIMEOUT_EN
  logic [7:0]               cnt_q, cnt_d;
`endif

  // Address decode and handshake/ack qualifiers shared by both comb blocks
  always_comb begin
    region_bits = Mem_Data_Addr >> REGION_SHIFT;
    req_idx     = region_bits[IDX_W-1:0] & IDX_W'(NUM_TARGETS - 1);
    decode_err  = (region_bits >> IDX_EFF) != '0;
    null_req    = (Mem_Write_Ctrl == '0) && !Mem_Read_Ctrl;
    accept      = (state_q == IDLE) && ready_q && Req_Valid;
    ack_hit     = Tgt_Ack[idx_q];
`ifdef SOC_IC_TIMEOUT_EN
    timeout_hit = (cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
    timeout_hit = 1'b0;
`endif
  end

  // State register plus every registered output and captured request field
  always_ff @(posedge Clk_Core) begin
    if (Rst_Core) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      read_q      <= 1'b0;
      sel_q       <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rdata_q     <= '0;
`ifdef SOC_IC_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      read_q      <= read_d;
      sel_q       <= sel_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rdata_q     <= rdata_d;
`ifdef SOC_IC_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Next-state logic: short-circuit to RESP for decode errors and null requests
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (decode_err || null_req) state_d = RESP;
          else                        state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (ack_hit || timeout_hit) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath logic: capture on accept, complete on ack or timeout
  always_comb begin
    idx_d       = idx_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    read_d      = read_q;
    rsp_error_d = rsp_error_q;
    rdata_d     = rdata_q;
`ifdef SOC_IC_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          idx_d   = req_idx;
          addr_d  = Mem_Data_Addr[REGION_SHIFT-1:0];
          wdata_d = Mem_Data_Write;
          wstrb_d = Mem_Write_Ctrl;
          read_d  = Mem_Read_Ctrl;
          if (decode_err) begin
            rsp_error_d = 1'b1;
            rdata_d     = '0;
          end else if (null_req) begin
            rsp_error_d = 1'b0;
            rdata_d     = '0;
          end
`ifdef SOC_IC_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      ACCESS: begin
        if (ack_hit) begin
          rsp_error_d = 1'b0;
          rdata_d     = read_q ? Tgt_Rdata[idx_q*DATA_W +: DATA_W] : '0;
        end else if (timeout_hit) begin
          rsp_error_d = 1'b1;
          rdata_d     = '0;
        end
`ifdef SOC_IC_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      default: ;
    endcase
    ready_d     = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    sel_d       = '0;
    if (state_d == ACCESS) sel_d[idx_d] = 1'b1;
  end

  assign Req_Ready     = ready_q;
  assign Rsp_Valid     = rsp_valid_q;
  assign Rsp_Error     = rsp_error_q;
  assign Mem_Data_Read = rdata_q;
  assign Tgt_Sel       = sel_q;
  assign Tgt_Addr      = addr_q;
  assign Tgt_Wdata     = wdata_q;
  assign Tgt_Wstrb     = wstrb_q;
  assign Tgt_Read      = read_q;

endmodule

// File: doc/soc_data_interconnect.md
# soc_data_interconnect

Parametrised data-side interconnect between the core's load/store port and NUM_TARGETS memory-mapped targets (data RAM, peripherals). It replaces the single hard-wired data memory connection with address-decoded routing, a valid/ready request handshake, variable-latency target acknowledge, decode-error and timeout reporting. One request is outstanding at a time, and the response is registered.

## Interface
Parameters:
- NUM_TARGETS, 4, number of targets; power of two, 1..16
- DATA_W, 32, data width; multiple of 8
- ADDR_W, 32, address width
- REGION_SHIFT, 12, log2 of the region size; each target owns a 2^REGION_SHIFT-byte window
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles before an error; 2..255

Ports:
- Clk_Core  in  1  single clock; all logic on the rising edge
- Rst_Core  in  1  synchronous, active-high reset
- Req_Valid  in  1  core request valid
- Req_Ready  out  1  interconnect can accept a request
- Mem_Data_Addr  in  ADDR_W  byte address
- Mem_Data_Write  in  DATA_W  write data
- Mem_Write_Ctrl  in  DATA_W/8  byte write strobes
- Mem_Read_Ctrl  in  1  read request
- Rsp_Valid  out  1  one-cycle response pulse
- Mem_Data_Read  out  DATA_W  read data; valid while Rsp_Valid is high
- Rsp_Error  out  1  decode or timeout error; qualified by Rsp_Valid
- Tgt_Sel  out  NUM_TARGETS  one-hot target select
- Tgt_Addr  out  REGION_SHIFT  offset within the region
- Tgt_Wdata  out  DATA_W  registered write data
- Tgt_Wstrb  out  DATA_W/8  registered write strobes
- Tgt_Read  out  1  registered read request
- Tgt_Ack  in  NUM_TARGETS  per-target completion
- Tgt_Rdata  in  NUM_TARGETS*DATA_W  flattened read data; target i occupies bits [i*DATA_W +: DATA_W]

## Operation
Decode:
- IDX_W = log2(NUM_TARGETS).
- Target index = Mem_Data_Addr[REGION_SHIFT +: IDX_W].
- Any set bit in Mem_Data_Addr[ADDR_W-1 : REGION_SHIFT+IDX_W] is a decode error.

The FSM has three states, IDLE, ACCESS and RESP:
- **IDLE:**
  - Req_Ready = 1.
  - On Req_Valid, the request is accepted. Address, write data, strobes, read bit and decoded index are captured.
  - Decode error: go to RESP with error = 1. No target is touched.
  - Null request (strobes = 0 and Mem_Read_Ctrl = 0): go to RESP with error = 0 and read data = 0. No target is touched.
  - Otherwise: go to ACCESS with the timeout counter cleared.
- **ACCESS:**
  - Req_Ready = 0.
  - Tgt_Sel[idx] = 1. Tgt_Addr, Tgt_Wdata, Tgt_Wstrb and Tgt_Read are held stable.
  - Tgt_Ack[idx] = 1: capture Tgt_Rdata slice idx (zero if Tgt_Read = 0) and go to RESP with error = 0.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES-1 with no ack, go to RESP with error = 1 and read data = 0.
  - Ack takes priority over timeout in the same cycle.
  - Acks from non-selected targets are ignored.
- **RESP:**
  - Rsp_Valid = 1 for exactly one cycle, with Mem_Data_Read and Rsp_Error valid.
  - Req_Ready = 0.
  - Next state is IDLE.

General rules:
- A request with both read and write strobes set is forwarded as-is; the target performs the write and returns the read data.
- The target-side bus is driven only from registers. Tgt_Sel = 0 outside ACCESS.
- Mem_Data_Read holds its last value outside RESP. Consumers must qualify it with Rsp_Valid.

## Timing
- Reset: all outputs are driven from registers.
  - Req_Ready = 0 during reset and 1 on the first cycle after release.
  - Rsp_Valid, Rsp_Error, Mem_Data_Read, Tgt_Sel, Tgt_Addr, Tgt_Wdata, Tgt_Wstrb and Tgt_Read are all 0.
- Handshake: a request is accepted on the edge where Req_Valid and Req_Ready are both high. The core must hold the request until it is accepted.
- Latency: accept at edge T. Tgt_Sel is high from T+1. An ack k cycles into ACCESS (k ≥ 0) gives Rsp_Valid at cycle T+2+k.
  - Minimum accept-to-response is 2 cycles.
  - Decode-error and null requests respond at T+1.
- Throughput: a new request can be accepted every 3 cycles at best (IDLE→ACCESS→RESP→IDLE).
- Reset mid-operation: on the edge where Rst_Core is sampled high, the FSM goes to IDLE with reset output values. No response is produced for the aborted request. Tgt_Sel drops after that edge.

## Configuration
- SOC_IC_TIMEOUT_EN
  - Defined: the timeout counter and timeout error are present, as described above.
  - Undefined: the counter logic is removed, and ACCESS waits for Tgt_Ack indefinitely. Rsp_Error is asserted only for decode errors. TIMEOUT_CYCLES is ignored.

## Test plan
Directed scenarios, with NUM_TARGETS=4, REGION_SHIFT=12 and TIMEOUT_CYCLES=16 unless stated:
- **Read from target 2:** read at 0x0000_2010; target 2 acks in the first ACCESS cycle with 0xDEAD_BEEF. Expect Tgt_Sel=4'b0100 and Tgt_Addr=0x010, then Rsp_Valid 2 cycles after accept with data 0xDEAD_BEEF and Rsp_Error=0.
- **Write with wait states:** write 0x1234_5678, strobes 4'b0011, to 0x0000_3004; target 3 acks after 5 wait cycles. Expect Tgt_Wstrb=4'b0011 held for 6 cycles, then Rsp_Valid at accept+7 with error 0.
- **Decode error:** access to 0x0001_0000. Expect no Tgt_Sel activity, then Rsp_Valid at accept+1 with Rsp_Error=1 and data 0.
- **Timeout:** target 1 never acks.
  - With SOC_IC_TIMEOUT_EN defined: expect Rsp_Valid at accept+17 with Rsp_Error=1; also an ack in the final ACCESS cycle returns data with error 0.
  - With the macro undefined: no response is produced until the ack arrives.
- **Handshake, null request, wrong-target ack:** Req_Valid held high during RESP. Expect Req_Ready=0 and no acceptance until IDLE. A null request returns at accept+1 with data 0 and error 0. An ack from target 0 while target 2 is selected is ignored.
- **Reset mid-operation:** Rst_Core pulsed during ACCESS. Expect Tgt_Sel=0 after that edge, no Rsp_Valid, and Req_Ready=1 on the first cycle after release.
